// File: rtl/fw_loader.sv
// fw_loader: boot-time firmware loader placed in front of the cpu core.
// Streams FW_LENGTH words from a valid/ready source into the core's RAM
// write port, keeps the core in reset while loading, then releases it
// RELEASE_DELAY cycles after the last accepted word.
// Optional checksum word and ERROR state: define FW_CHECKSUM_EN.
//
// Handshake: a word transfers on a rising edge where s_valid and s_ready are
// both 1; s_ready is combinational from the state and never depends on
// s_valid; s_valid while s_ready is 0 has no effect.
module fw_loader #(
  parameter int CPU_WIDTH     = 32,
  parameter int RAM_WIDTH     = 31,
  parameter int FW_LENGTH     = 19,
  parameter int COUNTER_WIDTH = 12,
  parameter int RELEASE_DELAY = 4
) (
  input  logic                 clk,
  input  logic                 a_reset_n,
  input  logic                 s_valid,
  input  logic [CPU_WIDTH-1:0] s_data,
  output logic                 s_ready,
  output logic                 ram_we,
  output logic [RAM_WIDTH-1:0] ram_addr,
  output logic [CPU_WIDTH-1:0] ram_wdata,
  output logic                 cpu_reset_n,
  output logic                 load_done,
  output logic                 load_error,
  output logic [2:0]           fsm_state
);

  typedef enum logic [2:0] {
    LOAD    = 3'd0,
    CHECK   = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    ERROR   = 3'd4
  } state_t;

  // An empty image skips straight to the release countdown.
  localparam state_t RESET_STATE = (FW_LENGTH == 0) ? RELEASE : LOAD;
  localparam int DW = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
  localparam logic [DW-1:0] DELAY_LAST = DW'(RELEASE_DELAY - 1);
  localparam logic [COUNTER_WIDTH-1:0] LAST_WORD = COUNTER_WIDTH'(FW_LENGTH - 1);

  state_t                   state;
  state_t                   next_state;
  logic [COUNTER_WIDTH-1:0] word_cnt;
  logic [DW-1:0]            delay_cnt;
  logic                     handshake;
  logic                     last_word;
  logic                     release_done;

  assign handshake    = s_valid & s_ready;
  assign last_word    = (word_cnt == LAST_WORD);
  assign release_done = (state == RELEASE) && (delay_cnt == DELAY_LAST);
  assign fsm_state    = state;

`ifdef FW_CHECKSUM_EN
  logic [CPU_WIDTH-1:0] sum;
  logic                 sum_ok;
  assign sum_ok = (s_data == sum);
`endif

  // State register.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) state <= RESET_STATE;
    else            state <= next_state;
  end

  // Next-state decode and the combinational ready.
  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    case (state)
      LOAD: begin
        s_ready = 1'b1;
        if (handshake && last_word) begin
`ifdef FW_CHECKSUM_EN
          next_state = CHECK;
`else
          next_state = RELEASE;
`endif
        end
      end
`ifdef FW_CHECKSUM_EN
      CHECK: begin
        s_ready = 1'b1;
        if (handshake) next_state = sum_ok ? RELEASE : ERROR;
      end
      ERROR:   next_state = ERROR;
`endif
      RELEASE: if (release_done) next_state = RUN;
      RUN:     next_state = RUN;
      default: next_state = RESET_STATE;
    endcase
  end

  // RAM write port, word counter, release countdown and core reset.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      cpu_reset_n <= 1'b0;
      load_done   <= 1'b0;
      word_cnt    <= '0;
      delay_cnt   <= '0;
    end else begin
      ram_we <= 1'b0;
      if (state == LOAD && handshake) begin
        ram_we    <= 1'b1;
        ram_addr  <= RAM_WIDTH'({word_cnt, 2'b00});
        ram_wdata <= s_data;
        word_cnt  <= word_cnt + 1'b1;
      end
      if (state == RELEASE) begin
        if (release_done) begin
          cpu_reset_n <= 1'b1;
          load_done   <= 1'b1;
        end else begin
          delay_cnt <= delay_cnt + 1'b1;
        end
      end
    end
  end

`ifdef FW_CHECKSUM_EN
  // Running wrap-around sum of data words and the sticky error flag.
  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      sum        <= '0;
      load_error <= 1'b0;
    end else begin
      if (state == LOAD && handshake) sum <= sum + s_data;
      if (state == CHECK && handshake && !sum_ok) load_error <= 1'b1;
    end
  end
`else
  assign load_error = 1'b0;
`endif

endmodule

// File: tb/tb_fw_loader.sv
// Directed bench for fw_loader: table-driven cycle vectors plus hand-written
// reset and empty-image sequences, with a write scoreboard.
module tb_fw_loader;

  localparam int CW = 32;
  localparam int RW = 31;
  localparam int NW = 4;

  localparam logic [2:0] ST_LOAD  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_REL   = 3'd2;
  localparam logic [2:0] ST_ERROR = 3'd4;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic a_reset_n;

  logic          s_valid;
  logic [CW-1:0] s_data;
  logic          s_ready, ram_we, cpu_reset_n, load_done, load_error;
  logic [RW-1:0] ram_addr;
  logic [CW-1:0] ram_wdata;
  logic [2:0]    fsm_state;

  logic          z_ready, z_we, z_rstn, z_done, z_err;
  logic [RW-1:0] z_addr;
  logic [CW-1:0] z_wdata;
  logic [2:0]    z_state;

  fw_loader #(.CPU_WIDTH(CW), .RAM_WIDTH(RW), .FW_LENGTH(NW),
              .COUNTER_WIDTH(12), .RELEASE_DELAY(4)) dut (
    .clk(clk), .a_reset_n(a_reset_n), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .cpu_reset_n(cpu_reset_n), .load_done(load_done),
    .load_error(load_error), .fsm_state(fsm_state));

  fw_loader #(.CPU_WIDTH(CW), .RAM_WIDTH(RW), .FW_LENGTH(0),
              .COUNTER_WIDTH(12), .RELEASE_DELAY(4)) dut0 (
    .clk(clk), .a_reset_n(a_reset_n), .s_valid(s_valid), .s_data(s_data),
    .s_ready(z_ready), .ram_we(z_we), .ram_addr(z_addr),
    .ram_wdata(z_wdata), .cpu_reset_n(z_rstn), .load_done(z_done),
    .load_error(z_err), .fsm_state(z_state));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [CW-1:0] words [NW] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0020_81B3};
  logic [CW-1:0] good_sum;

  // Scoreboard of expected RAM writes {addr, data}.
  logic [RW+CW-1:0] exp_q[$];
  int wr_idx = 0;

  always @(negedge clk) begin
    if (a_reset_n) begin
      chk("len0_s_ready", 64'(z_ready), 64'd0);
      chk("len0_ram_we", 64'(z_we), 64'd0);
      if (ram_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 64'(exp_q.size()), 64'd1);
        end else begin
          logic [RW+CW-1:0] e;
          e = exp_q.pop_front();
          chk("sb_addr", 64'(ram_addr), 64'(e[RW+CW-1:CW]));
          chk("sb_data", 64'(ram_wdata), 64'(e[CW-1:0]));
        end
      end
    end
  end

  // Vector table: inputs for one cycle, ready during it, outputs after the edge.
  typedef struct {
    logic          valid;
    logic [CW-1:0] data;
    logic          ready;
    logic          we;
    logic [RW-1:0] addr;
    logic [CW-1:0] wdata;
    logic          rstn;
    logic          done;
    logic          err;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic valid, input logic [CW-1:0] data, input logic ready,
                     input logic we, input logic [RW-1:0] addr, input logic [CW-1:0] wdata,
                     input logic rstn, input logic done, input logic err);
    vec_t v;
    v.valid = valid; v.data = data; v.ready = ready; v.we = we; v.addr = addr;
    v.wdata = wdata; v.rstn = rstn; v.done = done; v.err = err;
    tbl.push_back(v);
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i]) begin
      vec_t v;
      v = tbl[i];
      s_valid = v.valid;
      s_data  = v.data;
      if (v.valid && v.ready && wr_idx < NW) begin
        exp_q.push_back({RW'(wr_idx * 4), v.data});
        wr_idx++;
      end
      #1 chk($sformatf("%s[%0d].s_ready", tag, i), 64'(s_ready), 64'(v.ready));
      @(posedge clk);
      #1;
      chk($sformatf("%s[%0d].ram_we", tag, i), 64'(ram_we), 64'(v.we));
      if (v.we) begin
        chk($sformatf("%s[%0d].ram_addr", tag, i), 64'(ram_addr), 64'(v.addr));
        chk($sformatf("%s[%0d].ram_wdata", tag, i), 64'(ram_wdata), 64'(v.wdata));
      end
      chk($sformatf("%s[%0d].cpu_reset_n", tag, i), 64'(cpu_reset_n), 64'(v.rstn));
      chk($sformatf("%s[%0d].load_done", tag, i), 64'(load_done), 64'(v.done));
      chk($sformatf("%s[%0d].load_error", tag, i), 64'(load_error), 64'(v.err));
    end
    s_valid = 1'b0;
    tbl.delete();
  endtask

  // Release tail: three cycles still in reset, then core released, then held.
  task automatic add_release_tail(input logic valid);
    for (int k = 0; k < 3; k++) add(valid, 32'hDEAD_0000 + k, 0, 0, '0, '0, 0, 0, 0);
    for (int k = 0; k < 4; k++) add(valid, 32'hBEEF_0000 + k, 0, 0, '0, '0, 1, 1, 0);
  endtask

  task automatic build_held();
    for (int i = 0; i < NW; i++) add(1, words[i], 1, 1, RW'(4 * i), words[i], 0, 0, 0);
`ifdef FW_CHECKSUM_EN
    add(1, good_sum, 1, 0, '0, '0, 0, 0, 0);
`endif
    add_release_tail(1'b1);
  endtask

  task automatic build_alt();
    for (int i = 0; i < NW; i++) begin
      add(0, 32'hFFFF_FFFF, 1, 0, '0, '0, 0, 0, 0);
      add(1, words[i], 1, 1, RW'(4 * i), words[i], 0, 0, 0);
    end
`ifdef FW_CHECKSUM_EN
    add(0, 32'hFFFF_FFFF, 1, 0, '0, '0, 0, 0, 0);
    add(1, good_sum, 1, 0, '0, '0, 0, 0, 0);
`endif
    add_release_tail(1'b0);
  endtask

  // Asynchronous reset pulse: checks take effect before any clock edge.
  task automatic do_reset();
    a_reset_n = 1'b0;
    s_valid   = 1'b0;
    #3;
    chk("rst.cpu_reset_n", 64'(cpu_reset_n), 64'd0);
    chk("rst.load_done", 64'(load_done), 64'd0);
    chk("rst.load_error", 64'(load_error), 64'd0);
    chk("rst.ram_we", 64'(ram_we), 64'd0);
    chk("rst.ram_addr", 64'(ram_addr), 64'd0);
    chk("rst.ram_wdata", 64'(ram_wdata), 64'd0);
    chk("rst.s_ready", 64'(s_ready), 64'd1);
    chk("rst.state", 64'(fsm_state), 64'(ST_LOAD));
    chk("rst.len0_state", 64'(z_state), 64'(ST_REL));
    chk("rst.len0_cpu_reset_n", 64'(z_rstn), 64'd0);
    @(negedge clk);
    a_reset_n = 1'b1;
    wr_idx = 0;
  endtask

  initial begin
    a_reset_n = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    good_sum  = '0;
    for (int i = 0; i < NW; i++) good_sum = good_sum + words[i];
    #1;
    do_reset();

    // Empty image: release exactly RELEASE_DELAY edges after reset deassertion.
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("len0.cpu_reset_n@%0d", k), 64'(z_rstn), 64'(k == 4));
      chk($sformatf("len0.load_done@%0d", k), 64'(z_done), 64'(k == 4));
    end

    // Back-to-back words, then extra words ignored after load.
    build_held();
    run_table("held");
    chk("held.state", 64'(fsm_state), 64'(ST_RUN));

    // Reset from RUN drops the core reset immediately.
    @(negedge clk);
    #1 do_reset();

    // Gapped stream.
    build_alt();
    run_table("alt");
    chk("alt.state", 64'(fsm_state), 64'(ST_RUN));

    // Reset after two accepted words, then a full reload from address 0.
    @(negedge clk);
    #1 do_reset();
    for (int i = 0; i < 2; i++) add(1, words[i], 1, 1, RW'(4 * i), words[i], 0, 0, 0);
    run_table("part");
    @(negedge clk);
    #1 do_reset();
    build_held();
    run_table("reload");
    chk("reload.state", 64'(fsm_state), 64'(ST_RUN));

`ifdef FW_CHECKSUM_EN
    // Bad checksum: terminal ERROR with the core kept in reset.
    @(negedge clk);
    #1 do_reset();
    for (int i = 0; i < NW; i++) add(1, words[i], 1, 1, RW'(4 * i), words[i], 0, 0, 0);
    add(1, 32'h0000_0000, 1, 0, '0, '0, 0, 0, 1);
    for (int k = 0; k < 6; k++) add(1, 32'h1234_0000 + k, 0, 0, '0, '0, 0, 0, 1);
    run_table("bad_sum");
    chk("bad_sum.state", 64'(fsm_state), 64'(ST_ERROR));
`endif

    repeat (2) @(negedge clk);
    #1 chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
